// File: rtl/periph_bus_pkg.sv
// Shared definitions for the two-requester peripheral bus arbiter:
// access encodings, FSM state type, error data pattern and helpers.
package periph_bus_pkg;

    localparam logic [1:0] ACC_IDLE = 2'b11;
    localparam logic [1:0] ACC_WORD = 2'b10;
    localparam logic [1:0] ACC_HALF = 2'b01;
    localparam logic [1:0] ACC_BYTE = 2'b00;

    localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic acc_active(
        input logic [1:0] write_n,
        input logic [1:0] read_n
    );
        return (write_n != ACC_IDLE) || (read_n != ACC_IDLE);
    endfunction

endpackage

// File: rtl/periph_rr_arb.sv
// Two-way round-robin grant. Ports: req[1:0] active requests, last_grant
// (0=m0, 1=m1), grant (winner index), grant_valid (any request active).
module periph_rr_arb (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_valid
);

    assign grant_valid = |req;

    always_comb begin
        grant = 1'b0;
        case (req)
            2'b11:   grant = ~last_grant;
            2'b10:   grant = 1'b1;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/periph_bus_arb.sv
// Arbitrates two requesters (m0/m1) onto one peripheral bus with a
// IDLE/BUSY/DONE handshake, round-robin grant and a BUSY-wait timeout.
// Ports: clk, rst_n (async low); m*_addr/write_n/read_n/data_out request
// inputs; m*_data_ready/m*_data_in completion outputs; p_* shared bus;
// p_ready/p_data_in peripheral response; p_read_complete read-accept
// pulse; timeout_err sticky flag cleared by clr_err.
module periph_bus_arb
    import periph_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int ADDR_W         = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [1:0]        m0_write_n,
    input  logic [1:0]        m0_read_n,
    input  logic [31:0]       m0_data_out,
    output logic              m0_data_ready,
    output logic [31:0]       m0_data_in,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [1:0]        m1_write_n,
    input  logic [1:0]        m1_read_n,
    input  logic [31:0]       m1_data_out,
    output logic              m1_data_ready,
    output logic [31:0]       m1_data_in,
    output logic [ADDR_W-1:0] p_addr,
    output logic [1:0]        p_write_n,
    output logic [1:0]        p_read_n,
    output logic [31:0]       p_data_out,
    input  logic              p_ready,
    input  logic [31:0]       p_data_in,
    output logic              p_read_complete,
    output logic              timeout_err,
    input  logic              clr_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1
                         : $clog2(TIMEOUT_CYCLES + 1);
    // Last BUSY cycle index before the forced error completion.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic              grant_q;
    logic              last_grant_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [1:0]        data_ready_q;

    logic [1:0]        req;
    logic              arb_grant;
    logic              arb_valid;

    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        sel_write_n;
    logic [1:0]        sel_read_n;
    logic [31:0]       sel_data;
    logic              sel_active;
    logic              sel_wr;
    logic              busy;
    logic              done_ok;
    logic              timed_out;

    assign req[0] = acc_active(m0_write_n, m0_read_n);
    assign req[1] = acc_active(m1_write_n, m1_read_n);

    periph_rr_arb u_rr_arb (
        .req         (req),
        .last_grant  (last_grant_q),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    assign sel_addr    = grant_q ? m1_addr     : m0_addr;
    assign sel_write_n = grant_q ? m1_write_n  : m0_write_n;
    assign sel_read_n  = grant_q ? m1_read_n   : m0_read_n;
    assign sel_data    = grant_q ? m1_data_out : m0_data_out;
    assign sel_active  = req[grant_q];
    assign sel_wr      = (sel_write_n != ACC_IDLE);

    assign busy      = (state == ST_BUSY);
    assign done_ok   = busy && sel_active && p_ready;
    assign timed_out = busy && sel_active && !p_ready
                    && (wait_cnt == CNT_LAST);

    // Write has priority, so a simultaneous read is masked off the bus.
    assign p_addr     = busy ? sel_addr : '0;
    assign p_write_n  = busy ? sel_write_n : ACC_IDLE;
    assign p_read_n   = (busy && !sel_wr) ? sel_read_n : ACC_IDLE;
    assign p_data_out = busy ? sel_data : 32'h0;

    assign p_read_complete = done_ok && !sel_wr;

    assign m0_data_ready = data_ready_q[0];
    assign m1_data_ready = data_ready_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wait_cnt     <= '0;
            data_ready_q <= 2'b00;
            m0_data_in   <= 32'h0;
            m1_data_in   <= 32'h0;
            timeout_err  <= 1'b0;
        end else begin
            data_ready_q <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_q      <= arb_grant;
                        last_grant_q <= arb_grant;
                        wait_cnt     <= '0;
                        state        <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!sel_active) begin
                        // Requester withdrew: abandon silently.
                        state <= ST_IDLE;
                    end else if (p_ready) begin
                        state                 <= ST_DONE;
                        data_ready_q[grant_q] <= 1'b1;
                        if (!sel_wr) begin
                            if (grant_q) m1_data_in <= p_data_in;
                            else         m0_data_in <= p_data_in;
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        state                 <= ST_DONE;
                        data_ready_q[grant_q] <= 1'b1;
                        if (grant_q) m1_data_in <= ERR_DATA;
                        else         m0_data_in <= ERR_DATA;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            // A new timeout beats a same-cycle clear.
            if (timed_out)    timeout_err <= 1'b1;
            else if (clr_err) timeout_err <= 1'b0;
        end
    end

endmodule
